// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the fetch port (if_*) and
// the data port (dm_*). One access is in flight at a time. A winner is chosen
// and issued in the same IDLE cycle. Reads then wait MEM_LAT cycles for
// mem_rdata, stores complete right away. Each access ends with a one-cycle
// ready pulse on the owning port.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_ready     fetched word (registered) and completion pulse
//   dm_req/dm_wen/dm_addr/dm_wdata
//                         data request (load or store)
//   dm_rdata/dm_ready     load data (registered) and completion pulse
//   mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata
//                         unified memory port
//   if_stall/dm_stall     pipeline freeze per port
//   dbg_state             current FSM state (IDLE/WAIT/RESP)
//
// Handshake: a requester raises req together with its address/data and holds
// them stable until it sees ready high for one cycle. The cycle after ready
// is the earliest next issue, and it is also the cycle in which the requester
// drops req or presents a new request. If req falls before ready, the access
// in flight still runs to completion and still pulses ready.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_wen,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              dm_stall,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // The counter only ever holds MEM_LAT-1.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STK_W = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [STK_W-1:0]  streak;
    logic              owner_dm;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic issue;
    logic grant_if;
    logic grant_dm;
    logic streak_max;

    assign streak_max = (streak == STK_W'(MAX_DM_STREAK));

    // Issue happens in the decision cycle, so mem_en is combinational. It is
    // also gated by reset so that the port is quiet while reset is asserted.
    assign issue    = (state == IDLE) && (if_req || dm_req) && reset;
    // Data wins by default. Fetch wins when it is the only requester, or when
    // data has already taken MAX_DM_STREAK grants in a row while fetch waited.
    assign grant_if = issue && if_req && (!dm_req || streak_max);
    assign grant_dm = issue && dm_req && !grant_if;

    always_comb begin
        mem_en    = issue;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm) begin
            mem_wen   = dm_wen;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_dm   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        owner_dm <= grant_dm;
                        if (grant_dm && dm_wen) begin
                            // The memory commits the write in the issue cycle.
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_W'(MEM_LAT - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner_dm) begin
                            dm_rdata_q <= mem_rdata;
                        end else begin
                            if_rdata_q <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Counts data grants taken while a fetch was waiting. It saturates at
    // MAX_DM_STREAK and clears whenever fetch is served or nobody was waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_dm) begin
            if (!if_req) begin
                streak <= '0;
            end else if (!streak_max) begin
                streak <= streak + 1'b1;
            end
        end
    end

    assign if_ready  = (state == RESP) && !owner_dm;
    assign dm_ready  = (state == RESP) && owner_dm;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req && !if_ready;
    assign dm_stall  = dm_req && !dm_ready;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiter instances share one clock and one reset: index 0 uses
// MEM_LAT=2 and carries the main scenarios, index 1 uses MEM_LAT=1, and
// index 2 uses MEM_LAT=4. Each instance has its own behavioural memory that
// returns read data exactly MEM_LAT cycles after mem_en. Expected load and
// fetch data for instance 0 are queued when a request is driven and compared
// when the matching ready pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam logic [1:0] IDLE = 2'd0;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic        if_req   [3];
  logic [31:0] if_addr  [3];
  logic [31:0] if_rdata [3];
  logic        if_ready [3];
  logic        dm_req   [3];
  logic        dm_wen   [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];
  logic [31:0] dm_rdata [3];
  logic        dm_ready [3];
  logic        mem_en   [3];
  logic        mem_wen  [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata[3];
  logic        if_stall [3];
  logic        dm_stall [3];
  logic [1:0]  dbg_state[3];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] model_mem[256];
  logic [31:0] dm_hold;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h0050_0093;
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // ---------------- DUTs and memory models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_DM_STREAK(3)
    ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]),
      .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
      .dm_req(dm_req[g]), .dm_wen(dm_wen[g]), .dm_addr(dm_addr[g]),
      .dm_wdata(dm_wdata[g]), .dm_rdata(dm_rdata[g]), .dm_ready(dm_ready[g]),
      .mem_en(mem_en[g]), .mem_wen(mem_wen[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .if_stall(if_stall[g]), .dm_stall(dm_stall[g]), .dbg_state(dbg_state[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    end

    // Non-read cycles load a poison word so early or late sampling shows up.
    always @(posedge clk) begin
      if (mem_en[g] && mem_wen[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_wen[g]) ? mem[mem_addr[g][9:2]] : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard for instance 0.
  always @(negedge clk) begin
    if (if_ready[0]) begin
      if (exp_if_q.size() == 0) check("if_ready_unexpected", 32'd1, 32'd0);
      else check("if_rdata", if_rdata[0], exp_if_q.pop_front());
    end
    if (dm_ready[0]) begin
      if (exp_dm_q.size() == 0) check("dm_ready_unexpected", 32'd1, 32'd0);
      else check("dm_rdata", dm_rdata[0], exp_dm_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for a ready pulse on port p (0=fetch, 1=data) of instance n.
  // The port's stall must be high on every cycle before ready and low at ready.
  task automatic wait_ready(input int n, input bit p, output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p ? dm_ready[n] : if_ready[n]) begin
        at = cyc;
        check("stall_at_ready", 32'(p ? dm_stall[n] : if_stall[n]), 32'd0);
        break;
      end
      check("stall_while_waiting", 32'(p ? dm_stall[n] : if_stall[n]), 32'd1);
    end
    if (at < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch_test(input int n, input logic [31:0] addr, input int lat);
    int t0;
    int at;
    logic [31:0] exp;
    next_cycle();
    if_req[n] = 1'b1;
    if_addr[n] = addr;
    t0 = cyc;
    exp = (n == 0) ? model_mem[addr[9:2]] : init_word(int'(addr[9:2]));
    if (n == 0) exp_if_q.push_back(exp);
    @(negedge clk);
    check("fetch_mem_en", 32'(mem_en[n]), 32'd1);
    check("fetch_mem_wen", 32'(mem_wen[n]), 32'd0);
    check("fetch_mem_addr", mem_addr[n], addr);
    check("fetch_stall_issue", 32'(if_stall[n]), 32'd1);
    wait_ready(n, 1'b0, at);
    check("fetch_latency", 32'(at - t0), 32'(lat + 1));
    if (n != 0) check("fetch_rdata_sweep", if_rdata[n], exp);
    next_cycle();
    if_req[n] = 1'b0;
    @(negedge clk);
    check("fetch_ready_one_cycle", 32'(if_ready[n]), 32'd0);
    check("fetch_rdata_hold", if_rdata[n], exp);
    check("fetch_idle_no_en", 32'(mem_en[n]), 32'd0);
  endtask

  // Starts a data access on instance 0 in the current cycle and returns in
  // the cycle after ready, with dm_req still high.
  task automatic dm_access(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat);
    int t0;
    int at;
    dm_req[0] = 1'b1;
    dm_wen[0] = wen;
    dm_addr[0] = addr;
    dm_wdata[0] = wdata;
    t0 = cyc;
    if (wen) begin
      model_mem[addr[9:2]] = wdata;
    end else begin
      dm_hold = model_mem[addr[9:2]];
    end
    exp_dm_q.push_back(dm_hold);
    @(negedge clk);
    check("dm_mem_en", 32'(mem_en[0]), 32'd1);
    check("dm_mem_wen", 32'(mem_wen[0]), 32'(wen));
    check("dm_mem_addr", mem_addr[0], addr);
    if (wen) check("dm_mem_wdata", mem_wdata[0], wdata);
    wait_ready(0, 1'b1, at);
    check("dm_latency", 32'(at - t0), 32'(lat));
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int t0;
    int at;
    int ts;
    int ngr;
    int pulses;
    bit stop;
    bit done;
    bit drop_if;
    bit drop_dm;
    logic [7:0] gseq;

    dm_hold = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    for (int n = 0; n < 3; n++) begin
      if_req[n] = 1'b0; if_addr[n] = '0;
      dm_req[n] = 1'b0; dm_wen[n] = 1'b0; dm_addr[n] = '0; dm_wdata[n] = '0;
    end

    // Reset values, with a request pending to show the port stays quiet.
    reset = 1'b0;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en[0]), 32'd0);
    check("rst_mem_wen", 32'(mem_wen[0]), 32'd0);
    check("rst_mem_addr", mem_addr[0], 32'd0);
    check("rst_mem_wdata", mem_wdata[0], 32'd0);
    check("rst_if_ready", 32'(if_ready[0]), 32'd0);
    check("rst_dm_ready", 32'(dm_ready[0]), 32'd0);
    check("rst_if_rdata", if_rdata[0], 32'd0);
    check("rst_dm_rdata", dm_rdata[0], 32'd0);
    check("rst_state", 32'(dbg_state[0]), 32'(IDLE));
    if_req[0] = 1'b0;
    next_cycle();
    reset = 1'b1;

    // Single fetch and latency sweep.
    fetch_test(0, 32'h10, 2);
    fetch_test(1, 32'h10, 1);
    fetch_test(2, 32'h10, 4);

    // Store then back-to-back load.
    next_cycle();
    ts = cyc;
    dm_access(1'b1, 32'h100, 32'hDEAD_BEEF, 1);
    check("load_issue_cycle", 32'(cyc - ts), 32'd2);
    dm_access(1'b0, 32'h100, 32'h0, 3);
    check("load_data_cycle", 32'(cyc - ts - 1), 32'd5);
    dm_req[0] = 1'b0;
    dm_wen[0] = 1'b0;

    // Collision: data wins first, fetch follows.
    next_cycle();
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    dm_req[0] = 1'b1; dm_wen[0] = 1'b0; dm_addr[0] = 32'h40;
    t0 = cyc;
    dm_hold = model_mem[16];
    exp_dm_q.push_back(dm_hold);
    exp_if_q.push_back(model_mem[8]);
    @(negedge clk);
    check("coll_mem_en", 32'(mem_en[0]), 32'd1);
    check("coll_mem_addr_dm", mem_addr[0], 32'h40);
    wait_ready(0, 1'b1, at);
    check("coll_dm_ready_cycle", 32'(at - t0), 32'd3);
    next_cycle();
    dm_req[0] = 1'b0;
    @(negedge clk);
    check("coll_if_issue", 32'(mem_en[0]), 32'd1);
    check("coll_mem_addr_if", mem_addr[0], 32'h20);
    check("coll_if_issue_cycle", 32'(cyc - t0), 32'd4);
    wait_ready(0, 1'b0, at);
    check("coll_if_ready_cycle", 32'(at - t0), 32'd7);
    next_cycle();
    if_req[0] = 1'b0;

    // Starvation guard: both ports keep requesting; the grant order must be
    // three data grants, one fetch, then three data grants and one fetch again.
    next_cycle();
    if_req[0] = 1'b1; if_addr[0] = 32'h30;
    dm_req[0] = 1'b1; dm_wen[0] = 1'b0; dm_addr[0] = 32'h50;
    gseq = '0; ngr = 0; stop = 1'b0; done = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (mem_en[0]) begin
        bit isd;
        isd = (mem_addr[0] == 32'h50);
        ngr++;
        if (ngr <= 8) gseq = {gseq[6:0], isd};
        if (isd) begin
          dm_hold = model_mem[20];
          exp_dm_q.push_back(dm_hold);
        end else begin
          exp_if_q.push_back(model_mem[12]);
        end
        if (ngr == 8) stop = 1'b1;
      end
      drop_if = stop && if_ready[0];
      drop_dm = stop && dm_ready[0];
      next_cycle();
      if (drop_if) if_req[0] = 1'b0;
      if (drop_dm) dm_req[0] = 1'b0;
      if (!if_req[0] && !dm_req[0] && dbg_state[0] == IDLE) begin
        done = 1'b1;
        break;
      end
    end
    check("starve_completed", 32'(done), 32'd1);
    check("starve_grant_order", 32'(gseq), 32'h000000EE);

    // Reset in the middle of a fetch read.
    next_cycle();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    next_cycle();
    reset = 1'b0;
    #1;
    check("midrst_mem_en", 32'(mem_en[0]), 32'd0);
    check("midrst_state", 32'(dbg_state[0]), 32'(IDLE));
    check("midrst_if_rdata", if_rdata[0], 32'd0);
    check("midrst_dm_rdata", dm_rdata[0], 32'd0);
    check("midrst_if_ready", 32'(if_ready[0]), 32'd0);
    dm_hold = '0;
    if_req[0] = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_ready[0]) pulses++;
    end
    check("midrst_no_ready", 32'(pulses), 32'd0);
    fetch_test(0, 32'h10, 2);

    repeat (3) next_cycle();
    check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    check("dm_queue_drained", 32'(exp_dm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported instruction/data memory between the CPU's fetch stage and memory-access stage. It grants one requester at a time, drives the memory port for a fixed read latency, returns data with a one-cycle ready pulse, and produces the per-port stall signals the pipeline uses to freeze. It sits between the pipeline registers and the unified memory. It replaces the separate instruction and data memory instances when the CPU is built against a single physical RAM.

## Interface
- ADDR_W, 32, address width for both ports and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from memory issue to valid mem_rdata. Legal range is MEM_LAT >= 1.
- MAX_DM_STREAK, 3, consecutive data-port grants allowed while a fetch waits.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_wen/dm_addr/dm_wdata until dm_ready.
- dm_wen  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; registered, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_wen  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- if_stall  out  1  if_req & ~if_ready (combinational).
- dm_stall  out  1  dm_req & ~dm_ready (combinational).

## Operation
- FSM states:
  - IDLE: no access in flight.
  - WAIT: read in flight; counter running.
  - RESP: ready pulse cycle.
- IDLE with no request: hold; mem_en=0.
- IDLE with a request: select a winner.
  - Default priority: dm > if, because the data access belongs to the older instruction.
  - Fairness override: if streak == MAX_DM_STREAK and if_req=1, fetch wins.
- Winner issue, same cycle as the decision:
  - mem_en=1; mem_addr/mem_wen/mem_wdata come from the winning port.
  - A fetch always issues with mem_wen=0.
  - The grant owner is latched.
- Store: go to RESP next cycle.
- Read: load counter to MEM_LAT-1 and go to WAIT.
  - WAIT decrements the counter each cycle.
  - At 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: assert the owner's ready for exactly one cycle, then return to IDLE. RESP never issues.
- Streak counter (saturating at MAX_DM_STREAK):
  - +1 on a dm grant while if_req=1.
  - Cleared on any fetch grant.
  - Cleared on a dm grant while if_req=0.
- rdata registers hold their value after ready falls. Only the owner's rdata register is updated.
- A request whose req drops before ready is protocol-illegal. The access in flight still completes and pulses ready.
- mem_* address and data outputs are don't-care when mem_en=0.

## Timing
- Reset values:
  - FSM = IDLE; counter = 0; streak = 0.
  - mem_en = mem_wen = 0; mem_addr = mem_wdata = 0.
  - if_ready = dm_ready = 0; if_rdata = dm_rdata = 0.
- Issue cycle T is the first IDLE cycle with a request; mem_en is high in T.
- Read latency: mem_rdata is sampled at the end of cycle T+MEM_LAT, and ready is high in cycle T+MEM_LAT+1.
- Store latency: ready is high in cycle T+1. The write is committed by the memory in T.
- The earliest next issue is the cycle after ready, which is also the cycle the requester must drop or update req.
- Throughput:
  - Back-to-back reads: one per MEM_LAT+2 cycles.
  - Back-to-back stores: one per 2 cycles.
- A simultaneous if_req/dm_req in IDLE yields exactly one grant. The loser's stall stays high and it is served at the next IDLE.
- Reset asserted mid-access: immediate return to IDLE. The in-flight read is discarded and no ready pulse is issued, including after reset releases.

## Test plan
- Single fetch:
  - Stimulus: MEM_LAT=2; if_req with if_addr=0x10; memory returns 0x00500093.
  - Response: mem_en in T; if_ready and if_rdata=0x00500093 in T+3; if_stall high T..T+2 and low in T+3.
- Store then load:
  - Stimulus: dm store 0xDEADBEEF to 0x100, then a load from 0x100.
  - Response: dm_ready at T+1; the load issues at T+2; dm_rdata=0xDEADBEEF at T+5.
- Collision:
  - Stimulus: if_req and dm_req (load) raised in the same cycle.
  - Response: mem_addr = dm_addr in T; dm_ready at T+3; the fetch issues at T+4; if_ready at T+7.
- Starvation guard:
  - Stimulus: if_req held high; dm_req re-raised every cycle after dm_ready; MAX_DM_STREAK=3.
  - Response: exactly 3 dm grants, then a fetch grant, then the streak restarts at 0.
- Reset mid-read:
  - Stimulus: reset pulled low in T+1 of a fetch, released 2 cycles later.
  - Response: all outputs go to reset values immediately; no if_ready ever appears for that access; a fresh if_req completes normally.
- Latency sweep:
  - Stimulus: repeat the single-fetch test with MEM_LAT=1 and MEM_LAT=4.
  - Response: ready appears at T+2 and T+5 respectively.
